// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arb_pkg
// Purpose : Shared constants for the ALU sharing arbiter. Holds the default
//           operand/control widths and the ALU control encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package alu_share_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 2;

  // ALU control encoding driven on alu_ctr
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_RSVD = 2'b11;

  // Reserved code: the result is forced to zero and flagged as an error
  function automatic logic is_rsvd(input logic [1:0] ctr);
    return (ctr == ALU_RSVD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arb_if
// Purpose : Bundles the two request ports, the ALU operand/result lines and
//           the response port of the ALU sharing arbiter.
// Ports   : req0_*/req1_*  valid/ready request handshakes with operands
//           alu_*          operands/control to the ALU, result back
//           rsp_*          valid/ready response with data, id and error
// Modports: slave  - arbiter view
//           master - environment view (requesters, ALU, consumer)
// Revision: 1.0  initial release
// ============================================================================
interface alu_share_arb_if #(
  parameter int DW = 32,
  parameter int CW = 2
);

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [CW-1:0] req0_ctr;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [CW-1:0] req1_ctr;

  logic [DW-1:0] alu_busA;
  logic [DW-1:0] alu_busB;
  logic [CW-1:0] alu_ctr;
  logic [DW-1:0] alu_out;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
  logic          rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctr,
    output req1_ready,
    output alu_busA, alu_busB, alu_ctr,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctr,
    input  req1_ready,
    input  alu_busA, alu_busB, alu_ctr,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way round-robin grant. A lone valid requester wins; when both
//           are valid the one that did not win last time is granted.
// Ports   : valid0_i, valid1_i  request valids
//           last_grant_i        index of the most recent accepted requester
//           gnt_valid_o         some requester is granted
//           gnt_id_o            index of the granted requester
// Revision: 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    gnt_id_o    = 1'b0;
    if (valid0_i && valid1_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (valid1_i) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arb
// Purpose : Shares one combinational ALU between two requesters (0 = main
//           datapath, 1 = address/branch-offset path). Round-robin grant,
//           operands muxed onto the ALU, result captured into a one-entry
//           response register tagged with the requester id.
// Ports   : clk              clock, rising edge
//           rst_n            synchronous active-low reset
//           bus_if (slave)   request/ALU/response signal bundle
//           gnt0_cnt/gnt1_cnt  16-bit saturating accept counters
//                            (only with ALU_SHARE_ARB_STATS_EN defined)
// Options : ALU_SHARE_ARB_STATS_EN enables the per-requester grant counters.
// Revision: 1.0  initial release
// ============================================================================
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arb_if.slave       bus_if
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]          gnt0_cnt,
  output logic [15:0]          gnt1_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Response register and arbitration state
  // --------------------------------------------------------------------------
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic          rsp_id_q,    rsp_id_d;
  logic          rsp_err_q,   rsp_err_d;
  logic          last_grant_q, last_grant_d;
  // Lock remembers a winner that was granted but stalled by back-pressure,
  // so a late-arriving competitor cannot steal the grant from it.
  logic          lock_q,    lock_d;
  logic          lock_id_q, lock_id_d;

  logic          can_accept;
  logic          lock_hold;
  logic          arb_valid0;
  logic          arb_valid1;
  logic          gnt_valid;
  logic          gnt_id;
  logic          accept;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic [CW-1:0] sel_ctr;
  logic          sel_rsvd;

  // Free, or being drained by the consumer in this same cycle.
  assign can_accept = !rsp_valid_q || bus_if.rsp_ready;

  // The lock only bites while the stalled winner still presents its request.
  assign lock_hold  = lock_q && (lock_id_q ? bus_if.req1_valid : bus_if.req0_valid);
  assign arb_valid0 = bus_if.req0_valid && !(lock_hold && lock_id_q);
  assign arb_valid1 = bus_if.req1_valid && !(lock_hold && !lock_id_q);

  rr_arb2 u_arb (
    .valid0_i     (arb_valid0),
    .valid1_i     (arb_valid1),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  // No handshake may complete while reset is asserted.
  assign accept = gnt_valid && can_accept && rst_n;

  assign bus_if.req0_ready = accept && !gnt_id;
  assign bus_if.req1_ready = accept &&  gnt_id;

  // --------------------------------------------------------------------------
  // ALU operand mux: granted requester's fields, or 0 + 0 when idle
  // --------------------------------------------------------------------------
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_ctr = ALU_ADD;
    if (gnt_valid) begin
      if (gnt_id) begin
        sel_a   = bus_if.req1_a;
        sel_b   = bus_if.req1_b;
        sel_ctr = bus_if.req1_ctr;
      end else begin
        sel_a   = bus_if.req0_a;
        sel_b   = bus_if.req0_b;
        sel_ctr = bus_if.req0_ctr;
      end
    end
  end

  assign sel_rsvd        = is_rsvd(sel_ctr);
  assign bus_if.alu_busA = sel_a;
  assign bus_if.alu_busB = sel_b;
  assign bus_if.alu_ctr  = sel_ctr;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    lock_d       = 1'b0;
    lock_id_d    = lock_id_q;
    if (accept) begin
      // Covers the drain-and-refill case: the register is overwritten.
      rsp_valid_d  = 1'b1;
      rsp_data_d   = sel_rsvd ? '0 : bus_if.alu_out;
      rsp_id_d     = gnt_id;
      rsp_err_d    = sel_rsvd;
      last_grant_d = gnt_id;
    end else begin
      if (rsp_valid_q && bus_if.rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
      if (gnt_valid && !can_accept) begin
        lock_d    = 1'b1;
        lock_id_d = gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      // Pretend requester 1 won last, so requester 0 wins the first contention.
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
    end
  end

  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.rsp_id    = rsp_id_q;
  assign bus_if.rsp_err   = rsp_err_q;

`ifdef ALU_SHARE_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating per-requester accept counters
  // --------------------------------------------------------------------------
  logic [15:0] gnt0_cnt_q;
  logic [15:0] gnt1_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      if (accept && !gnt_id && (gnt0_cnt_q != 16'hFFFF)) begin
        gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
      end
      if (accept && gnt_id && (gnt1_cnt_q != 16'hFFFF)) begin
        gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
      end
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 32-bit ALU (ADD/SUB/OR) between two requesters: port 0 is the main datapath, port 1 is the auxiliary address/branch-offset path.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Drives the ALU operand/control lines combinationally from the granted request.
- Captures the ALU result into a one-entry response register tagged with the requester id.

Parameters:
- DW, 32, operand/result width.
- CW, 2, ALU control width. Encoding: ADD=2'b00, SUB=2'b01, OR=2'b10, 2'b11 reserved.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  DW each  requester 0 operands
- req0_ctr  in  CW  requester 0 ALU control
- req1_valid, req1_ready, req1_a, req1_b, req1_ctr  same as requester 0, for requester 1
- alu_busA, alu_busB  out  DW each  operands to ALU
- alu_ctr  out  CW  control to ALU
- alu_out  in  DW  ALU combinational result
- rsp_valid  out  1  response register full
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DW  captured result
- rsp_id  out  1  requester that issued the response
- rsp_err  out  1  reserved control code was used

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-operation discards any held response; no request is accepted in the reset cycle.
- can_accept = !rsp_valid || rsp_ready. Register is free, or is being drained in the same cycle.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - req*_ready = grant[*] && can_accept. At most one ready is high per cycle.
  - A requester's valid/operands must stay stable until it sees ready. The arbiter does not re-arbitrate away from a stalled winner; grant holds while !can_accept.
- ALU drive:
  - alu_busA/B/ctr = granted requester's fields.
  - With no valid request, drive 0/0/ADD.
- Accept (handshake at a clk edge):
  - rsp_data <= alu_out, rsp_id <= granted index, rsp_valid <= 1, last_grant <= granted index.
  - Reserved ctr 2'b11: rsp_data <= 0, rsp_err <= 1. Otherwise rsp_err <= 0.
- Latency: exactly one cycle from accept to rsp_valid.
- Throughput: one op/cycle when rsp_ready is held high (drain and accept happen in the same cycle).
- rsp_ready && rsp_valid with no new accept: rsp_valid <= 0; data/id/err hold their last values.
- Back-pressure: rsp_valid=1 && rsp_ready=0 holds the response register stable and both readys are low.
- Arithmetic: modulo 2^DW. No overflow flag; SUB wraps.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt0_cnt and gnt1_cnt, each 16 bits.
  - Each increments on an accepted operation from its requester, saturating at 16'hFFFF.
  - Both clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: ALU control constants ALU_ADD, ALU_SUB, ALU_OR, ALU_RSVD, plus the DW/CW defaults.
- One sub-module, rr_arb2: 2-way round-robin grant from {valid1, valid0, last_grant}.
- Response register and handshake logic stay in the top.

Test Plan:
1. Reset, then req0 alone: a=5, b=3, ctr=ADD. Expect req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_data=8, rsp_id=0, rsp_err=0.
2. Both valid for 4 consecutive cycles, rsp_ready=1. req0 is ADD 1+1; req1 is SUB 2-5. Grants alternate 0,1,0,1. Responses are 2, 32'hFFFFFFFD, 2, 32'hFFFFFFFD.
3. rsp_ready=0 with a response held, and a new req1 valid. req1_ready stays 0 and rsp_data is stable for 3 cycles. Raise rsp_ready: drain and accept occur in the same cycle, with no bubble.
4. req1 with ctr=2'b11, a=7, b=9. Expect rsp_err=1, rsp_data=0, rsp_id=1. A following OR 0xF0|0x0F gives 0xFF with rsp_err=0.
5. Drive rst_n=0 while rsp_valid=1 and both requests valid. The next edge gives rsp_valid=0. After release, req0 wins contention first.
6. With ALU_SHARE_ARB_STATS_EN defined: 3 req0 accepts and 2 req1 accepts give gnt0_cnt=3, gnt1_cnt=2. Preload gnt0_cnt to 16'hFFFE, then two more req0 accepts leave gnt0_cnt saturated at 16'hFFFF.
